trng_ctrl: RTL and testbench



---
 rtl/trng_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_trng_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trng_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : trng_ctrl                                                     |
// | Purpose  : Sequencing and health-monitoring controller for the ring-     |
// |            oscillator TRNG. Samples the synchronized TRNG word every     |
// |            SAMPLE_DIV clocks, discards WARMUP samples after each enable, |
// |            runs a repetition-count health test and buffers passing      |
// |            samples in a first-word-fall-through FIFO.                    |
// | Ports    : clk, rst        - clock, synchronous active-high reset        |
// |            enable          - level, run sampling when high               |
// |            clear_fault     - pulse, leaves the FAULT state               |
// |            trng_in         - synchronized TRNG word                      |
// |            out_data/valid  - FIFO head word and its valid flag           |
// |            out_ready       - consumer pops on out_valid & out_ready      |
// |            fault           - sticky health-test failure flag             |
// |            level           - exact FIFO occupancy                        |
// |            busy            - sampling active (warm-up or run)            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module trng_ctrl #(
   parameter int WIDTH      = 32,
   parameter int SAMPLE_DIV = 16,
   parameter int WARMUP     = 4,
   parameter int REP_LIMIT  = 3,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enable,
   input  logic                          clear_fault,
   input  logic [WIDTH-1:0]              trng_in,
   output logic [WIDTH-1:0]              out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          fault,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          busy
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int LVL_W  = PTR_W + 1;
   localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int WARM_W = $clog2(WARMUP + 1);
   localparam int REP_W  = $clog2(REP_LIMIT + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WARMUP = 2'd1,
      ST_RUN    = 2'd2,
      ST_FAULT  = 2'd3
   } state_t;

   state_t              state, next_state;

   logic [DIV_W-1:0]    div_cnt;
   logic [WARM_W-1:0]   warm_cnt;
   logic [REP_W-1:0]    rep_cnt;
   logic [REP_W-1:0]    rep_next;
   logic [WIDTH-1:0]    prev_sample;
   logic                prev_valid;

   logic                active;
   logic                strobe;
   logic                health_fail;
   logic                push_req;
   logic                flush;

   logic [WIDTH-1:0]    mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr, rd_ptr;
   logic [LVL_W-1:0]    count;
   logic                push, pop;

   // ---------------------------------------------------------------------
   // Strobe and health-test evaluation
   // ---------------------------------------------------------------------
   // Dropping enable wins over a coincident strobe: the interval in progress
   // is abandoned and that sample is never evaluated.
   assign active      = (state == ST_WARMUP) || (state == ST_RUN);
   assign strobe      = active && enable && (div_cnt == DIV_W'(SAMPLE_DIV - 1));
   assign rep_next    = (prev_valid && (trng_in == prev_sample)) ? rep_cnt + 1'b1
                                                                 : REP_W'(1);
   assign health_fail = strobe && (rep_next >= REP_W'(REP_LIMIT));

   // ---------------------------------------------------------------------
   // State machine
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      push_req   = 1'b0;
      flush      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (enable) next_state = ST_WARMUP;
         end
         ST_WARMUP: begin
            if (!enable) begin
               next_state = ST_IDLE;
            end else if (health_fail) begin
               next_state = ST_FAULT;
               flush      = 1'b1;
            end else if (strobe && (warm_cnt == WARM_W'(WARMUP - 1))) begin
               next_state = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!enable) begin
               next_state = ST_IDLE;
            end else if (health_fail) begin
               next_state = ST_FAULT;
               flush      = 1'b1;
            end else if (strobe) begin
               push_req   = 1'b1;
            end
         end
         ST_FAULT: begin
            if (clear_fault) next_state = enable ? ST_WARMUP : ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Sampling counters and health-test history
   // ---------------------------------------------------------------------
   // Outside WARMUP/RUN the counters are held cleared, so any entry into
   // WARMUP (from IDLE or straight from FAULT) starts a fresh warm-up.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt     <= '0;
         warm_cnt    <= '0;
         rep_cnt     <= '0;
         prev_sample <= '0;
         prev_valid  <= 1'b0;
      end else if (active && enable) begin
         div_cnt <= strobe ? '0 : div_cnt + 1'b1;
         if (strobe) begin
            prev_sample <= trng_in;
            prev_valid  <= 1'b1;
            rep_cnt     <= rep_next;
            if (state == ST_WARMUP) warm_cnt <= warm_cnt + 1'b1;
         end
      end else begin
         div_cnt    <= '0;
         warm_cnt   <= '0;
         rep_cnt    <= '0;
         prev_valid <= 1'b0;
      end
   end

   // ---------------------------------------------------------------------
   // Output FIFO (first-word-fall-through)
   // ---------------------------------------------------------------------
   // A pop in the same cycle frees the slot, so a push into a full FIFO is
   // accepted when the consumer is popping.
   assign pop  = out_valid && out_ready;
   assign push = push_req && ((count != LVL_W'(FIFO_DEPTH)) || pop);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= trng_in;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign out_valid = (count != '0);
   assign out_data  = out_valid ? mem[rd_ptr] : '0;
   assign level     = count;
   assign fault     = (state == ST_FAULT);
   assign busy      = active;

endmodule
`default_nettype wire

// File: tb/tb_trng_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_trng_ctrl                                                  |
// | Purpose  : Self-checking bench for trng_ctrl with an abstract queue-based|
// |            reference model, directed scenarios and randomized traffic.  |
// | Ports    : none                                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_trng_ctrl;

   localparam int WIDTH      = 32;
   localparam int SAMPLE_DIV = 4;
   localparam int WARMUP     = 2;
   localparam int REP_LIMIT  = 3;
   localparam int FIFO_DEPTH = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             enable = 1'b0;
   logic             clear_fault = 1'b0;
   logic [WIDTH-1:0] trng_in = '0;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic             fault;
   logic [2:0]       level;
   logic             busy;

   int tests = 0;
   int fails = 0;

   trng_ctrl #(
      .WIDTH      (WIDTH),
      .SAMPLE_DIV (SAMPLE_DIV),
      .WARMUP     (WARMUP),
      .REP_LIMIT  (REP_LIMIT),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .clear_fault (clear_fault),
      .trng_in     (trng_in),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .fault       (fault),
      .level       (level),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------
   // Reference model: cycles since activation, strobe count, run length of
   // identical samples and a queue standing in for the FIFO.
   // ---------------------------------------------------------------------
   logic [WIDTH-1:0] mq[$];
   bit               m_started = 0;
   bit               m_active  = 0;
   bit               m_faulted = 0;
   int               m_t       = 0;
   int               m_nstrobe = 0;
   int               m_run     = 0;
   bit               m_have    = 0;
   logic [WIDTH-1:0] m_last    = '0;

   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            m_started = 1;
            m_active  = 0;
            m_faulted = 0;
            mq.delete();
         end else begin
            bit do_pop;
            bit start;
            do_pop = (mq.size() > 0) && out_ready;
            start  = 0;
            if (m_faulted) begin
               if (clear_fault) begin
                  m_faulted = 0;
                  start     = enable;
               end
            end else if (!m_active) begin
               if (do_pop) void'(mq.pop_front());
               start = enable;
            end else if (!enable) begin
               m_active = 0;
               if (do_pop) void'(mq.pop_front());
            end else begin
               bit is_strobe;
               is_strobe = (m_t % SAMPLE_DIV) == SAMPLE_DIV - 1;
               m_t++;
               if (is_strobe) begin
                  m_run  = (m_have && trng_in == m_last) ? m_run + 1 : 1;
                  m_last = trng_in;
                  m_have = 1;
               end
               if (is_strobe && m_run >= REP_LIMIT) begin
                  m_faulted = 1;
                  m_active  = 0;
                  mq.delete();
               end else begin
                  if (do_pop) void'(mq.pop_front());
                  if (is_strobe) begin
                     if (m_nstrobe < WARMUP) m_nstrobe++;
                     else if (mq.size() < FIFO_DEPTH) mq.push_back(trng_in);
                  end
               end
            end
            if (start) begin
               m_active  = 1;
               m_t       = 0;
               m_nstrobe = 0;
               m_run     = 0;
               m_have    = 0;
            end
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (m_started) begin
            check("m_level",  32'(level),     32'(mq.size()));
            check("m_valid",  32'(out_valid), 32'(mq.size() > 0));
            check("m_data",   out_data,       (mq.size() > 0) ? mq[0] : 32'h0);
            check("m_fault",  32'(fault),     32'(m_faulted));
            check("m_busy",   32'(busy),      32'(m_active));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   logic [31:0] exp_drain [4];

   initial begin
      logic [31:0] base;
      // Reset state
      tick();
      tick();
      rst = 1'b0;
      check("rst_level", 32'(level), 0);
      check("rst_valid", 32'(out_valid), 0);
      check("rst_data",  out_data, 0);
      check("rst_fault", 32'(fault), 0);
      check("rst_busy",  32'(busy), 0);

      // First delivery latency, fill to full, drops, push+pop while full
      base   = 32'h1000_0000;
      enable = 1'b1;
      for (int j = 0; j <= 36; j++) begin
         trng_in   = base + j;
         out_ready = (j == 36);
         tick();
         check("t1_busy",  32'(busy), 1);
         check("t1_valid", 32'(out_valid), 32'(j >= 12));
         if (j == 12) check("t1_data", out_data, base + 12);
         if (j == 32) check("t3_level_full", 32'(level), 4);
      end
      check("t4_level", 32'(level), 4);
      check("t4_head",  out_data, base + 16);
      out_ready = 1'b0;
      enable    = 1'b0;
      tick();
      exp_drain[0] = base + 16;
      exp_drain[1] = base + 20;
      exp_drain[2] = base + 24;
      exp_drain[3] = base + 36;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("t4_drain", out_data, exp_drain[i]);
         tick();
      end
      out_ready = 1'b0;
      check("t4_empty", 32'(level), 0);

      // Enable dropped after one warm-up strobe, then full warm-up repeats
      base = 32'h2000_0000;
      for (int j = 0; j <= 18; j++) begin
         trng_in = base + j;
         enable  = (j != 5);
         tick();
         check("t5_valid", 32'(out_valid), 32'(j >= 18));
      end
      check("t5_data", out_data, base + 18);

      // Constant input: two more pushes, then fault on the third repeat
      for (int j = 19; j <= 30; j++) begin
         trng_in = 32'hDEAD_BEEF;
         tick();
         check("t2_fault", 32'(fault), 32'(j >= 30));
         if (j == 29) check("t2_level_pre", 32'(level), 3);
      end
      check("t2_level", 32'(level), 0);
      check("t2_valid", 32'(out_valid), 0);
      check("t2_busy",  32'(busy), 0);
      clear_fault = 1'b1;
      tick();
      clear_fault = 1'b0;
      check("t2_clr_fault", 32'(fault), 0);
      check("t2_clr_busy",  32'(busy), 1);

      // Reset while running with three words buffered
      base = 32'h3000_0000;
      for (int j = 1; j <= 20; j++) begin
         trng_in = base + j;
         tick();
      end
      check("t6_level_pre", 32'(level), 3);
      rst = 1'b1;
      tick();
      check("t6_run_level", 32'(level), 0);
      check("t6_run_valid", 32'(out_valid), 0);
      check("t6_run_fault", 32'(fault), 0);
      check("t6_run_busy",  32'(busy), 0);
      rst     = 1'b0;
      trng_in = 32'hDEAD_BEEF;
      for (int j = 0; j <= 12; j++) tick();
      check("t6_fault_pre", 32'(fault), 1);
      rst = 1'b1;
      tick();
      check("t6_flt_level", 32'(level), 0);
      check("t6_flt_valid", 32'(out_valid), 0);
      check("t6_flt_fault", 32'(fault), 0);
      check("t6_flt_busy",  32'(busy), 0);
      rst    = 1'b0;
      enable = 1'b0;

      // Randomized traffic against the model
      for (int c = 0; c < 4000; c++) begin
         bit narrow;
         narrow      = ((c / 500) % 2) == 0;
         rst         = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 59) == 0) enable = ~enable;
         clear_fault = ($urandom_range(0, 19) == 0);
         out_ready   = ($urandom_range(0, 2) != 0);
         trng_in     = narrow ? 32'($urandom_range(0, 2)) : $urandom;
         tick();
      end
      rst = 1'b0;
      enable = 1'b0;
      clear_fault = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
